tc_ram_param: RTL and testbench



---
 rtl/tc_ram_param.sv | 123 ++++++++++++
 tb/tb_tc_ram_param.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/tc_ram_param.sv
// Parametrised single-port RAM with registered read, valid flag and a multi-cycle zero-fill sweep.
// Latency: read data and out_valid appear one clock after the load edge; a sweep takes DEPTH edges.
// Backpressure: while busy is high, load, save and clear are ignored and out/out_valid stay zero.
// Optional build macro TC_RAM_WRITE_THROUGH_EN: a same-edge load+save returns the new data.
module tc_ram_param #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 256
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              load,
    input  logic              save,
    input  logic [ADDR_W-1:0] address,
    input  logic [DATA_W-1:0] in,
    output logic [DATA_W-1:0] out,
    output logic              out_valid,
    output logic              busy
);

    // One bit wider than the address so DEPTH == 2**ADDR_W is representable.
    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] LAST_L  = DEPTH_L - 1'b1;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    // Power-up values model the library RAM in simulation; rst is needed in hardware.
    state_t            state     = IDLE;
    logic [ADDR_W:0]   ptr       = '0;
    logic [DATA_W-1:0] mem [DEPTH] = '{default: '0};
    logic [DATA_W-1:0] out_q     = '0;
    logic              vld_q     = 1'b0;
    logic              busy_q    = 1'b1 ^ 1'b1;

    logic              in_range;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_dat;
    logic [DATA_W-1:0] rd_dat;

    assign out       = out_q;
    assign out_valid = vld_q;
    assign busy      = busy_q;

    // Addresses at or beyond DEPTH have no storage behind them.
    assign in_range = ({1'b0, address} < DEPTH_L);

    // Select the single memory write for this edge: reset/sweep zeroing wins over user writes.
    always_comb begin
        wr_en   = 1'b0;
        wr_addr = address;
        wr_dat  = in;
        rd_dat  = '0;
        if (rst) begin
            wr_en   = 1'b1;
            wr_addr = '0;
            wr_dat  = '0;
        end else if (state == CLEAR) begin
            wr_en   = 1'b1;
            wr_addr = ptr[ADDR_W-1:0];
            wr_dat  = '0;
        end else if (!clear && save && in_range) begin
            wr_en   = 1'b1;
        end
        if (in_range) begin
`ifdef TC_RAM_WRITE_THROUGH_EN
            rd_dat = save ? in : mem[address];
`else
            rd_dat = mem[address];
`endif
        end
    end

    // Memory array update.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_dat;
        end
    end

    // Sweep sequencer and registered read port.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= CLEAR;
            ptr    <= '0;
            busy_q <= 1'b1;
            out_q  <= '0;
            vld_q  <= 1'b0;
        end else begin
            case (state)
                CLEAR: begin
                    out_q <= '0;
                    vld_q <= 1'b0;
                    ptr   <= ptr + 1'b1;
                    if (ptr == LAST_L) begin
                        state  <= IDLE;
                        busy_q <= 1'b0;
                    end
                end
                default: begin
                    if (clear) begin
                        state  <= CLEAR;
                        ptr    <= '0;
                        busy_q <= 1'b1;
                        out_q  <= '0;
                        vld_q  <= 1'b0;
                    end else if (load) begin
                        out_q <= rd_dat;
                        vld_q <= 1'b1;
                    end else begin
                        out_q <= '0;
                        vld_q <= 1'b0;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tc_ram_param.sv
// Directed bench for tc_ram_param: a 16-word instance (full address space) and a 200-word instance (out-of-range).
// Expected outputs are queued when each step is driven and popped after the edge that produces them.
// Sampling happens 1 time unit after the rising edge; inputs change on the falling edge.
module tb_tc_ram_param;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // 16 x 8 instance
    logic       a_rst = 1'b0, a_clear = 1'b0, a_load = 1'b0, a_save = 1'b0;
    logic [3:0] a_addr = '0;
    logic [7:0] a_in = '0;
    logic [7:0] a_out;
    logic       a_vld, a_busy;

    // 200 x 8 instance
    logic       b_rst = 1'b0, b_clear = 1'b0, b_load = 1'b0, b_save = 1'b0;
    logic [7:0] b_addr = '0;
    logic [7:0] b_in = '0;
    logic [7:0] b_out;
    logic       b_vld, b_busy;

    tc_ram_param #(.DATA_W(8), .ADDR_W(4), .DEPTH(16)) dut_a (
        .clk(clk), .rst(a_rst), .clear(a_clear), .load(a_load), .save(a_save),
        .address(a_addr), .in(a_in), .out(a_out), .out_valid(a_vld), .busy(a_busy)
    );

    tc_ram_param #(.DATA_W(8), .ADDR_W(8), .DEPTH(200)) dut_b (
        .clk(clk), .rst(b_rst), .clear(b_clear), .load(b_load), .save(b_save),
        .address(b_addr), .in(b_in), .out(b_out), .out_valid(b_vld), .busy(b_busy)
    );

    typedef struct {
        logic [7:0] out;
        logic       vld;
        logic       busy;
        string      tag;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

`ifdef TC_RAM_WRITE_THROUGH_EN
    localparam logic [7:0] RDW_EXP = 8'h22;
`else
    localparam logic [7:0] RDW_EXP = 8'h11;
`endif

    // One clock step: drive at the falling edge, queue the expectation, check after the rising edge.
    task automatic cyc(input bit use_b, input logic r, input logic c, input logic l, input logic s,
                       input logic [7:0] a, input logic [7:0] d,
                       input logic [7:0] eo, input logic ev, input logic eb, input string tag);
        exp_t e;
        logic [7:0] got_o;
        logic       got_v, got_b;
        if (use_b) begin
            b_rst = r; b_clear = c; b_load = l; b_save = s; b_addr = a; b_in = d;
        end else begin
            a_rst = r; a_clear = c; a_load = l; a_save = s; a_addr = a[3:0]; a_in = d;
        end
        exp_q.push_back('{out: eo, vld: ev, busy: eb, tag: tag});
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        got_o = use_b ? b_out  : a_out;
        got_v = use_b ? b_vld  : a_vld;
        got_b = use_b ? b_busy : a_busy;
        total++;
        assert (got_o === e.out) else begin
            bad++;
            $error("FAIL %s out: got %0h want %0h", e.tag, got_o, e.out);
        end
        total++;
        assert (got_v === e.vld) else begin
            bad++;
            $error("FAIL %s out_valid: got %0b want %0b", e.tag, got_v, e.vld);
        end
        total++;
        assert (got_b === e.busy) else begin
            bad++;
            $error("FAIL %s busy: got %0b want %0b", e.tag, got_b, e.busy);
        end
        @(negedge clk);
    endtask

    initial begin
        @(negedge clk);

        // Reset held 3 cycles: outputs zero, busy high.
        for (int i = 0; i < 3; i++)
            cyc(0, 1, 0, 0, 0, 8'd0, 8'd0, 8'h00, 0, 1, "reset");
        // Sweep takes exactly 16 edges; load/save/clear during it are ignored.
        for (int i = 0; i < 16; i++)
            cyc(0, 0, 1, 1, 1, 8'd0, 8'hFF, 8'h00, 0, (i < 15), "rst_sweep");
        // Every word reads zero afterwards.
        for (int i = 0; i < 16; i++)
            cyc(0, 0, 0, 1, 0, 8'(i), 8'd0, 8'h00, 1, 0, "rst_readback");

        // Write then read with latency 1, then idle clears out.
        cyc(0, 0, 0, 0, 1, 8'd5, 8'hA5, 8'h00, 0, 0, "wr5");
        cyc(0, 0, 0, 1, 0, 8'd5, 8'h00, 8'hA5, 1, 0, "rd5");
        cyc(0, 0, 0, 0, 0, 8'd5, 8'h00, 8'h00, 0, 0, "idle_after_rd");

        // Same-edge load and save to one address.
        cyc(0, 0, 0, 0, 1, 8'd3, 8'h11, 8'h00, 0, 0, "wr3");
        cyc(0, 0, 0, 1, 1, 8'd3, 8'h22, RDW_EXP, 1, 0, "rdw3");
        cyc(0, 0, 0, 1, 0, 8'd3, 8'h00, 8'h22, 1, 0, "rd3_after");

        // Fill everything with FF and spot-check.
        for (int i = 0; i < 16; i++)
            cyc(0, 0, 0, 0, 1, 8'(i), 8'hFF, 8'h00, 0, 0, "fill");
        cyc(0, 0, 0, 1, 0, 8'd2, 8'h00, 8'hFF, 1, 0, "fill_chk2");
        cyc(0, 0, 0, 1, 0, 8'd15, 8'h00, 8'hFF, 1, 0, "fill_chk15");

        // Clear request with a same-edge save and load, both dropped.
        cyc(0, 0, 1, 1, 1, 8'd2, 8'h55, 8'h00, 0, 1, "clear_req");
        for (int i = 0; i < 16; i++)
            cyc(0, 0, 1, 1, 1, 8'd0, 8'hAA, 8'h00, 0, (i < 15), "clear_sweep");
        for (int i = 0; i < 16; i++)
            cyc(0, 0, 0, 1, 0, 8'(i), 8'd0, 8'h00, 1, 0, "clear_readback");

        // Reset in the middle of a sweep restarts it for a full 16 edges.
        cyc(0, 0, 0, 0, 1, 8'd15, 8'h3C, 8'h00, 0, 0, "wr15");
        cyc(0, 0, 1, 0, 0, 8'd0, 8'h00, 8'h00, 0, 1, "clear_req2");
        for (int i = 0; i < 6; i++)
            cyc(0, 0, 0, 1, 0, 8'd15, 8'h00, 8'h00, 0, 1, "sweep_pre_rst");
        cyc(0, 1, 0, 1, 0, 8'd15, 8'h00, 8'h00, 0, 1, "mid_rst");
        for (int i = 0; i < 16; i++)
            cyc(0, 0, 0, 1, 1, 8'd1, 8'h77, 8'h00, 0, (i < 15), "restart_sweep");
        cyc(0, 0, 0, 1, 0, 8'd15, 8'h00, 8'h00, 1, 0, "rd15_zero");
        cyc(0, 0, 0, 1, 0, 8'd1, 8'h00, 8'h00, 1, 0, "rd1_zero");

        // Out-of-range behaviour on the 200-word instance.
        cyc(1, 1, 0, 0, 0, 8'd0, 8'h00, 8'h00, 0, 1, "b_reset");
        for (int i = 0; i < 200; i++)
            cyc(1, 0, 0, 0, 0, 8'd0, 8'h00, 8'h00, 0, (i < 199), "b_sweep");
        cyc(1, 0, 0, 0, 1, 8'd199, 8'h42, 8'h00, 0, 0, "b_wr199");
        cyc(1, 0, 0, 0, 1, 8'd220, 8'h7E, 8'h00, 0, 0, "b_wr220");
        cyc(1, 0, 0, 0, 1, 8'd200, 8'h99, 8'h00, 0, 0, "b_wr200");
        cyc(1, 0, 0, 1, 0, 8'd220, 8'h00, 8'h00, 1, 0, "b_rd220");
        cyc(1, 0, 0, 1, 0, 8'd200, 8'h00, 8'h00, 1, 0, "b_rd200");
        cyc(1, 0, 0, 1, 0, 8'd199, 8'h00, 8'h42, 1, 0, "b_rd199");
        cyc(1, 0, 0, 1, 1, 8'd255, 8'h5A, 8'h00, 1, 0, "b_rdw255");
        cyc(1, 0, 0, 0, 0, 8'd0, 8'h00, 8'h00, 0, 0, "b_idle");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
